game_flow_ctrl: RTL and testbench
=================================

// Module: game_flow_ctrl
// PURPOSE
//  Game-flow controller sitting directly upstream of the display top level. Turns the raw start
//  switch, the combinational collision flag and the pipe-passed pulse into game_state, game_en,
//  game_reset, score and high score. It replaces free-running scoring with pass-based scoring and
//  adds collision filtering plus a game-over hold-off.
// PARAMETERS
//  COLL_FILT    4            consecutive collision cycles needed to end a game (>=1)
//  HOLD_CYCLES  100_000_000  cycles in GAMEOVER before a restart is accepted (1 s @ 100 MHz)
//  SCORE_MAX    9999         saturation value of score (fits 4-digit 7-seg)
//  CNT_W        27           width of hold counter (must hold HOLD_CYCLES-1)
// PORTS
//  clk          in   1   system clock
//  reset_n      in   1   asynchronous, active-low reset
//  start        in   1   level, OR of switches, asynchronous to clk
//  collision    in   1   level, combinational OR of collision detectors
//  pass_event   in   1   1-cycle pulse: bird cleared a pipe
//  game_state   out  3   one-hot: IDLE=3'b001, PLAYING=3'b010, GAMEOVER=3'b100
//  game_en      out  1   1 only in PLAYING
//  game_reset   out  1   1-cycle pulse resetting object/pipe engines on game start
//  score        out  14  binary, current game score
//  high_score   out  14  binary, best score since reset
//  new_high     out  1   1 while in GAMEOVER if the last game set a new high score
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low. While reset_n=0: game_state=IDLE,
//    game_en=0, game_reset=0, score=0, high_score=0, new_high=0, all counters 0.
//  - start: 2-FF synchroniser plus prev register, all reset to 1 (a switch held through reset
//    never auto-starts). start_rise = sync & ~prev. Start 0->1 sampled at edge N causes
//    game_state to change at edge N+3.
//  - IDLE: start_rise -> PLAYING. On that edge score<=0, coll_cnt<=0, game_reset<=1.
//  - PLAYING: game_en=1 (decoded from state). game_reset is high for exactly the first PLAYING
//    cycle. During that cycle collision and pass_event are ignored and coll_cnt is held at 0.
//  - Collision filter: coll_cnt increments when collision=1 and clears when collision=0.
//    If collision=1 with coll_cnt==COLL_FILT-1, the FSM moves to GAMEOVER on that edge.
//    Net effect: GAMEOVER exactly at the COLL_FILT-th consecutive high cycle.
//  - pass_event in PLAYING (not the game_reset cycle): score<=min(score+1, SCORE_MAX).
//    A pass_event coincident with the GAMEOVER transition edge is still counted.
//    pass_event in IDLE or GAMEOVER is ignored.
//  - GAMEOVER entry edge: hold_cnt<=0. On the first GAMEOVER cycle, if score>high_score then
//    high_score<=score and new_high<=1. score holds its value throughout GAMEOVER.
//  - GAMEOVER: hold_cnt counts up to HOLD_CYCLES-1, then saturates. Before saturation,
//    start_rise is discarded (not queued). After saturation, start_rise -> PLAYING with the same
//    actions as from IDLE; new_high<=0 on that edge.
//  - start_rise and the filter completing on the same edge in PLAYING: GAMEOVER wins
//    (start is ignored in PLAYING).
//  - Illegal/non-one-hot state -> IDLE on the next edge, outputs as in IDLE.
//  - reset_n asserted mid-game: immediate return to reset values, including high_score.
// TESTING
//  1. reset_n 0->1 with start held 1 -> stays IDLE; start 0 then 1 -> game_state=3'b010 three
//     clk later, game_reset=1 for exactly 1 cycle, game_en=1.
//  2. COLL_FILT=4, PLAYING: collision high 3 cycles, low 1, high 3 -> stays PLAYING; then high
//     4 cycles -> GAMEOVER on 4th edge, game_en=0.
//  3. 5 pass_events then GAMEOVER -> score=5, high_score=5, new_high=1. Next game: 3 passes then
//     GAMEOVER -> score=3, high_score=5, new_high=0.
//  4. HOLD_CYCLES=16: start toggle 10 cycles into GAMEOVER -> ignored. Toggle after 16 cycles ->
//     PLAYING, score=0, game_reset pulse.
//  5. SCORE_MAX=7: 10 pass_events -> score=7. pass_event on the same cycle as the 4th collision
//     cycle with score 3 -> score=4, high_score=4.
//  6. reset_n pulsed low mid-PLAYING with score=4 -> immediately IDLE, score=0, high_score=0,
//     game_reset=0, new_high=0.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// Game-flow controller: synchronises the start switch, filters collisions, counts pipe passes
// and tracks the high score across IDLE / PLAYING / GAMEOVER.
module game_flow_ctrl #(
    parameter int COLL_FILT   = 4,
    parameter int HOLD_CYCLES = 100_000_000,
    parameter int SCORE_MAX   = 9999,
    parameter int CNT_W       = 27
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        collision,
    input  logic        pass_event,
    output logic [2:0]  game_state,
    output logic        game_en,
    output logic        game_reset,
    output logic [13:0] score,
    output logic [13:0] high_score,
    output logic        new_high
);

    localparam int                COLL_W    = $clog2(COLL_FILT + 1);
    localparam logic [COLL_W-1:0] COLL_LAST = COLL_W'(COLL_FILT - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [13:0]       SCORE_SAT = 14'(SCORE_MAX);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'b001,
        ST_PLAYING  = 3'b010,
        ST_GAMEOVER = 3'b100
    } state_t;

    state_t             state_reg, state_next;
    logic [COLL_W-1:0]  coll_cnt_reg, coll_cnt_next;
    logic [CNT_W-1:0]   hold_cnt_reg, hold_cnt_next;
    logic [13:0]        score_reg, score_next;
    logic [13:0]        high_reg, high_next;
    logic               new_high_reg, new_high_next;
    logic               game_reset_reg, game_reset_next;
    logic               go_first_reg, go_first_next;

    logic               start_meta_reg, start_sync_reg, start_prev_reg;
    logic               start_rise_reg;
    logic [13:0]        score_inc;

    // Synchroniser chain resets high so a switch held through reset never looks like an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_meta_reg <= 1'b1;
            start_sync_reg <= 1'b1;
            start_prev_reg <= 1'b1;
            start_rise_reg <= 1'b0;
        end else begin
            start_meta_reg <= start;
            start_sync_reg <= start_meta_reg;
            start_prev_reg <= start_sync_reg;
            start_rise_reg <= start_sync_reg & ~start_prev_reg;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            coll_cnt_reg   <= '0;
            hold_cnt_reg   <= '0;
            score_reg      <= '0;
            high_reg       <= '0;
            new_high_reg   <= 1'b0;
            game_reset_reg <= 1'b0;
            go_first_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            coll_cnt_reg   <= coll_cnt_next;
            hold_cnt_reg   <= hold_cnt_next;
            score_reg      <= score_next;
            high_reg       <= high_next;
            new_high_reg   <= new_high_next;
            game_reset_reg <= game_reset_next;
            go_first_reg   <= go_first_next;
        end
    end

    assign score_inc = (score_reg >= SCORE_SAT) ? SCORE_SAT : score_reg + 14'd1;

    always_comb begin
        state_next      = state_reg;
        coll_cnt_next   = coll_cnt_reg;
        hold_cnt_next   = hold_cnt_reg;
        score_next      = score_reg;
        high_next       = high_reg;
        new_high_next   = new_high_reg;
        game_reset_next = 1'b0;
        go_first_next   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                coll_cnt_next = '0;
                if (start_rise_reg) begin
                    state_next      = ST_PLAYING;
                    score_next      = '0;
                    game_reset_next = 1'b1;
                end
            end
            ST_PLAYING: begin
                // The game_reset cycle lets the downstream engines settle; inputs are ignored.
                if (game_reset_reg) begin
                    coll_cnt_next = '0;
                end else begin
                    if (pass_event) begin
                        score_next = score_inc;
                    end
                    if (collision) begin
                        if (coll_cnt_reg == COLL_LAST) begin
                            state_next    = ST_GAMEOVER;
                            coll_cnt_next = '0;
                            hold_cnt_next = '0;
                            go_first_next = 1'b1;
                        end else begin
                            coll_cnt_next = coll_cnt_reg + COLL_W'(1);
                        end
                    end else begin
                        coll_cnt_next = '0;
                    end
                end
            end
            ST_GAMEOVER: begin
                coll_cnt_next = '0;
                if (go_first_reg && (score_reg > high_reg)) begin
                    high_next     = score_reg;
                    new_high_next = 1'b1;
                end
                // Restart edges arriving during the hold-off are dropped, not remembered.
                if (hold_cnt_reg != HOLD_LAST) begin
                    hold_cnt_next = hold_cnt_reg + CNT_W'(1);
                end else if (start_rise_reg) begin
                    state_next      = ST_PLAYING;
                    score_next      = '0;
                    new_high_next   = 1'b0;
                    game_reset_next = 1'b1;
                end
            end
            default: begin
                state_next    = ST_IDLE;
                coll_cnt_next = '0;
                hold_cnt_next = '0;
            end
        endcase
    end

    always_comb begin
        game_state = ST_IDLE;
        game_en    = 1'b0;
        case (state_reg)
            ST_PLAYING: begin
                game_state = ST_PLAYING;
                game_en    = 1'b1;
            end
            ST_GAMEOVER: game_state = ST_GAMEOVER;
            default:     game_state = ST_IDLE;
        endcase
    end

    assign game_reset = game_reset_reg;
    assign score      = score_reg;
    assign high_score = high_reg;
    assign new_high   = new_high_reg;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Testbench for game_flow_ctrl: drives whole games, pushes expected end-of-game results to a
// scoreboard queue and compares them when the DUT reaches GAMEOVER.
module tb_game_flow_ctrl;

    localparam int SCORE_MAX_TB = 7;
    localparam int HOLD_TB      = 16;
    localparam logic [2:0] S_IDLE = 3'b001;
    localparam logic [2:0] S_PLAY = 3'b010;
    localparam logic [2:0] S_OVER = 3'b100;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        collision;
    logic        pass_event;
    logic [2:0]  game_state;
    logic        game_en;
    logic        game_reset;
    logic [13:0] score;
    logic [13:0] high_score;
    logic        new_high;

    typedef struct {
        int sc;
        int hi;
        int nh;
    } go_exp_t;

    go_exp_t sb_q[$];
    int checks   = 0;
    int failures = 0;
    int model_score = 0;
    int model_high  = 0;

    game_flow_ctrl #(
        .COLL_FILT  (4),
        .HOLD_CYCLES(HOLD_TB),
        .SCORE_MAX  (SCORE_MAX_TB),
        .CNT_W      (5)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .collision (collision),
        .pass_event(pass_event),
        .game_state(game_state),
        .game_en   (game_en),
        .game_reset(game_reset),
        .score     (score),
        .high_score(high_score),
        .new_high  (new_high)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end else begin
            $display("check %s = %0d ok", tag, obs);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Produce a clean start edge and confirm the three-edge latency and the game_reset pulse.
    task automatic start_game(input logic [2:0] prev_state);
        start = 1'b0;
        tick(3);
        start = 1'b1;
        tick(3);
        check_val("start_latency_not_yet", game_state, prev_state);
        tick(1);
        check_val("start_state_playing", game_state, S_PLAY);
        check_val("start_game_reset_hi", game_reset, 1);
        check_val("start_game_en", game_en, 1);
        check_val("start_score_zero", score, 0);
        model_score = 0;
        // Inputs during the game_reset cycle must be ignored.
        pass_event = 1'b1;
        collision  = 1'b1;
        tick(1);
        pass_event = 1'b0;
        collision  = 1'b0;
        check_val("game_reset_one_cycle", game_reset, 0);
        check_val("reset_cycle_pass_ignored", score, 0);
    endtask

    task automatic do_passes(input int n);
        for (int i = 0; i < n; i++) begin
            pass_event = 1'b1;
            tick(1);
            pass_event = 1'b0;
            tick(1);
            model_score = (model_score + 1 > SCORE_MAX_TB) ? SCORE_MAX_TB : model_score + 1;
        end
    endtask

    task automatic end_game(input bit pass_on_last);
        go_exp_t e;
        int hit;
        hit = 0;
        if (pass_on_last)
            model_score = (model_score + 1 > SCORE_MAX_TB) ? SCORE_MAX_TB : model_score + 1;
        e.sc = model_score;
        if (model_score > model_high) begin
            model_high = model_score;
            e.nh = 1;
        end else begin
            e.nh = 0;
        end
        e.hi = model_high;
        sb_q.push_back(e);
        for (int i = 1; i <= 8 && hit == 0; i++) begin
            collision  = 1'b1;
            pass_event = (pass_on_last && i == 4);
            tick(1);
            if (game_state == S_OVER) hit = i;
        end
        collision  = 1'b0;
        pass_event = 1'b0;
        check_val("gameover_at_4th_coll", hit, 4);
        check_val("gameover_game_en", game_en, 0);
        tick(2);
        if (sb_q.size() == 0) begin
            check_val("scoreboard_empty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            check_val("go_score", score, e.sc);
            check_val("go_high_score", high_score, e.hi);
            check_val("go_new_high", new_high, e.nh);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        start      = 1'b1;
        collision  = 1'b0;
        pass_event = 1'b0;
        tick(3);
        check_val("rst_state", game_state, S_IDLE);
        check_val("rst_game_en", game_en, 0);
        check_val("rst_game_reset", game_reset, 0);
        check_val("rst_score", score, 0);
        check_val("rst_high", high_score, 0);
        check_val("rst_new_high", new_high, 0);
        reset_n = 1'b1;
        tick(6);
        check_val("held_start_stays_idle", game_state, S_IDLE);

        // Game A: collision filter with an interrupted burst.
        start_game(S_IDLE);
        collision = 1'b1;
        tick(3);
        collision = 1'b0;
        tick(1);
        collision = 1'b1;
        tick(3);
        collision = 1'b0;
        tick(1);
        check_val("filter_no_gameover", game_state, S_PLAY);
        end_game(1'b0);

        // Hold-off: a start edge roughly 10 cycles in is discarded and not queued.
        start = 1'b0;
        tick(6);
        start = 1'b1;
        tick(6);
        check_val("holdoff_ignored", game_state, S_OVER);
        tick(6);
        check_val("holdoff_not_queued", game_state, S_OVER);
        start_game(S_OVER);

        // Game B: new high score; Game C: lower score keeps the high.
        do_passes(5);
        check_val("score_after_5", score, model_score);
        end_game(1'b0);
        tick(HOLD_TB);
        start_game(S_OVER);
        check_val("restart_clears_new_high", new_high, 0);
        do_passes(3);
        end_game(1'b0);
        tick(HOLD_TB);
        start_game(S_OVER);

        // Game D: saturation at SCORE_MAX.
        do_passes(10);
        check_val("score_saturated", score, SCORE_MAX_TB);
        end_game(1'b0);

        // Fresh reset, then a pass coinciding with the final collision edge.
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        model_score = 0;
        model_high  = 0;
        tick(2);
        start_game(S_IDLE);
        do_passes(3);
        end_game(1'b1);

        // Asynchronous reset in the middle of a game.
        tick(HOLD_TB);
        start_game(S_OVER);
        do_passes(4);
        check_val("score_before_reset", score, 4);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("async_rst_state", game_state, S_IDLE);
        check_val("async_rst_score", score, 0);
        check_val("async_rst_high", high_score, 0);
        check_val("async_rst_game_reset", game_reset, 0);
        check_val("async_rst_new_high", new_high, 0);
        check_val("async_rst_game_en", game_en, 0);
        tick(2);
        reset_n = 1'b1;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
